// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI responder with oversampled SCK/SSEL/MOSI.
//
// Purpose:
//   Receives DATA_W-bit frames from an SPI master into a small RX FIFO and
//   returns the contents of a one-entry transmit holding register on MISO,
//   MSB first. All SPI inputs are resynchronised into clk_i.
//
// Ports:
//   clk_i, reset_n_i          system clock, asynchronous active-low reset
//   spi_ssel_i/sck_i/mosi_i   SPI bus inputs (asynchronous to clk_i)
//   spi_miso_o                SPI data out (0 while not selected)
//   tx_data_i/valid_i/ready_o transmit holding register (valid/ready)
//   rx_data_o/valid_o/ready_i RX FIFO head, first-word fall-through
//   busy_o                    synchronised SSEL active
//   rx_overflow_o             sticky: received word dropped, FIFO full
//   tx_underrun_o             sticky: frame load found holding register empty
//   frame_abort_o             sticky: SSEL released mid-frame
//   clear_i                   clears all sticky flags (set wins)
module spi_slave_if #(
  parameter int DATA_W   = 32,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              spi_ssel_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              rx_overflow_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o,
  input  logic              clear_i
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PTR_W  = $clog2(RX_DEPTH);
  localparam int FCNT_W = $clog2(RX_DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(RX_DEPTH);
  localparam logic SCK_IDLE = (CPOL != 0);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Synchronisers: two flops per input, plus one history flop each on SCK
  // and SSEL for edge detection.
  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic ssel_s1_q, ssel_s2_q, ssel_prev_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d, und_q, und_d, abort_q, abort_d;
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];

  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ssel_fall, ssel_rise;
  logic load, rx_push, abort_set, accept, pop, full, push_ok, ovf_set;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sck_s1_q    <= SCK_IDLE;
      sck_s2_q    <= SCK_IDLE;
      sck_prev_q  <= SCK_IDLE;
      ssel_s1_q   <= 1'b1;
      ssel_s2_q   <= 1'b1;
      ssel_prev_q <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sck_s1_q    <= spi_sck_i;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      ssel_s1_q   <= spi_ssel_i;
      ssel_s2_q   <= ssel_s1_q;
      ssel_prev_q <= ssel_s2_q;
      mosi_s1_q   <= spi_mosi_i;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      ovf_q       <= ovf_d;
      und_q       <= und_d;
      abort_q     <= abort_d;
    end
  end

  // FIFO storage carries no reset; the head is masked to 0 while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) rx_mem[wr_ptr_q] <= rx_shift_d;
  end

  assign sck_rise    = sck_s2_q & ~sck_prev_q;
  assign sck_fall    = ~sck_s2_q & sck_prev_q;
  assign lead_edge   = (CPOL == 0) ? sck_rise : sck_fall;
  assign trail_edge  = (CPOL == 0) ? sck_fall : sck_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign ssel_fall   = ~ssel_s2_q & ssel_prev_q;
  assign ssel_rise   = ssel_s2_q & ~ssel_prev_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ssel_fall) state_d = S_ACTIVE;
      S_ACTIVE: if (ssel_rise) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: shift registers, holding register, FIFO and flags.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    load        = 1'b0;
    rx_push     = 1'b0;
    abort_set   = 1'b0;
    if (state_q == S_IDLE) begin
      if (ssel_fall) begin
        bit_cnt_d = '0;
        load      = 1'b1;
      end
    end else if (ssel_rise) begin
      bit_cnt_d = '0;
      abort_set = (bit_cnt_q != '0);
    end else if (sample_edge) begin
      rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s2_q};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        rx_push   = 1'b1;
        load      = 1'b1;   // reload for a back-to-back frame
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (shift_edge && (bit_cnt_q != '0)) begin
      // No shift at bit 0 so the MSB stays on MISO for either CPHA.
      tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
    end
    if (load) tx_shift_d = hold_full_q ? hold_data_q : '0;

    // Holding register: a load empties it; an accept (only possible when
    // already empty) refills it, so the load always sees the old content.
    accept      = tx_valid_i & ~hold_full_q;
    hold_full_d = hold_full_q & ~load;
    hold_data_d = hold_data_q;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data_i;
    end

    // FIFO: a pop in the same cycle frees the slot for a push while full.
    pop      = rx_valid_o & rx_ready_i;
    full     = (fcnt_q == FULL_CNT);
    push_ok  = rx_push & (~full | pop);
    ovf_set  = rx_push & full & ~pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q + FCNT_W'(push_ok) - FCNT_W'(pop);

    ovf_d   = ovf_set | (ovf_q & ~clear_i);
    und_d   = (load & ~hold_full_q) | (und_q & ~clear_i);
    abort_d = abort_set | (abort_q & ~clear_i);
  end

  // Outputs.
  always_comb begin
    spi_miso_o    = (state_q == S_ACTIVE) & tx_shift_q[DATA_W-1];
    busy_o        = ~ssel_s2_q;
    tx_ready_o    = ~hold_full_q;
    rx_valid_o    = (fcnt_q != '0);
    rx_data_o     = rx_valid_o ? rx_mem[rd_ptr_q] : '0;
    rx_overflow_o = ovf_q;
    tx_underrun_o = und_q;
    frame_abort_o = abort_q;
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: instance 0 runs SPI mode 0, instance 1 mode 3.
// A bus-functional SPI master drives each instance; received words are
// tracked in a scoreboard queue and compared as the RX FIFO is drained.
module tb_spi_slave_if;

  localparam int H = 8;   // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ssel = 2'b11, sck = 2'b10, mosi = 2'b00, miso;
  logic [1:0]  tx_valid = 2'b00, tx_ready, rx_valid, rx_ready = 2'b00, busy;
  logic [1:0]  ovf, und, abrt, clr = 2'b00;
  logic [31:0] tx_data [2];
  logic [31:0] rx_data [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_slave_if #(.DATA_W(32), .CPOL(gi), .CPHA(gi), .RX_DEPTH(4)) u_dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .spi_ssel_i(ssel[gi]), .spi_sck_i(sck[gi]), .spi_mosi_i(mosi[gi]),
      .spi_miso_o(miso[gi]),
      .tx_data_i(tx_data[gi]), .tx_valid_i(tx_valid[gi]), .tx_ready_o(tx_ready[gi]),
      .rx_data_o(rx_data[gi]), .rx_valid_o(rx_valid[gi]), .rx_ready_i(rx_ready[gi]),
      .busy_o(busy[gi]), .rx_overflow_o(ovf[gi]), .tx_underrun_o(und[gi]),
      .frame_abort_o(abrt[gi]), .clear_i(clr[gi])
    );
  end

  typedef struct {
    int          mode;      // instance index: 0 = mode 0, 1 = mode 3
    bit          preload;   // load holding register before SSEL
    logic [31:0] hold;
    logic [31:0] mosi_w;
    logic [31:0] exp_miso;
    bit          exp_und;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [6:0] status(input int m);
    return {miso[m], tx_ready[m], rx_valid[m], busy[m], ovf[m], und[m], abrt[m]};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear(input int m);
    clr[m] = 1'b1;
    wait_clk(1);
    clr[m] = 1'b0;
  endtask

  task automatic push_tx(input int m, input logic [31:0] w);
    tx_data[m]  = w;
    tx_valid[m] = 1'b1;
    wait_clk(1);
    tx_valid[m] = 1'b0;
    check("tx_ready_after_accept", 32'(tx_ready[m]), 32'd0);
  endtask

  task automatic ssel_assert(input int m);
    ssel[m] = 1'b0;
    wait_clk(8);
  endtask

  task automatic ssel_release(input int m);
    wait_clk(H);
    ssel[m] = 1'b1;
    wait_clk(8);
  endtask

  // Master transfer of nbits, MSB first. With pop_on_last, rx_ready is
  // raised for exactly the cycle in which the last sample edge is detected
  // (two synchroniser stages after the SCK change), so pop and push coincide.
  task automatic xfer(input int m, input logic [31:0] w, input int nbits,
                      output logic [31:0] cap, input bit pop_on_last);
    logic cpol;
    cpol = (m == 1);
    cap  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (m == 0) begin
        mosi[m] = w[31-i];
        wait_clk(H);
        cap = {cap[30:0], miso[m]};
        sck[m] = ~cpol;
      end else begin
        sck[m] = ~cpol;
        mosi[m] = w[31-i];
        wait_clk(H);
        cap = {cap[30:0], miso[m]};
        sck[m] = cpol;
      end
      if (pop_on_last && i == nbits - 1) begin
        wait_clk(2);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL simul_pop_head: scoreboard empty");
        end else begin
          check("simul_pop_head", rx_data[m], sb.pop_front());
        end
        rx_ready[m] = 1'b1;
        wait_clk(1);
        rx_ready[m] = 1'b0;
        wait_clk(H - 3);
      end else begin
        wait_clk(H);
      end
      if (m == 0) sck[m] = cpol;
    end
  endtask

  task automatic pop_check(input int m, input string name);
    int t;
    t = 0;
    while (!rx_valid[m] && t < 50) begin
      wait_clk(1);
      t++;
    end
    if (!rx_valid[m]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: rx_valid timeout", name);
    end else if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: unexpected word %h", name, rx_data[m]);
    end else begin
      check(name, rx_data[m], sb.pop_front());
    end
    rx_ready[m] = 1'b1;
    wait_clk(1);
    rx_ready[m] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cap;
    tx_data[0] = '0;
    tx_data[1] = '0;
    vecs[0] = '{0, 1'b1, 32'hA5A5_0001, 32'h0000_0002, 32'hA5A5_0001, 1'b0};
    vecs[1] = '{0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h0F0F_55AA, 32'hCAFE_F00D, 32'h0F0F_55AA, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h0,         32'h1357_9BDF, 32'h0,         1'b1};
    vecs[4] = '{1, 1'b0, 32'h0,         32'h8000_0001, 32'h0,         1'b1};

    // Reset state.
    wait_clk(3);
    for (int m = 0; m < 2; m++) begin
      check("reset_status", 32'(status(m)), 32'b0100000);
      check("reset_rx_data", rx_data[m], 32'h0);
    end
    reset_n = 1'b1;
    wait_clk(4);

    // Table-driven single frames.
    for (int v = 0; v < 5; v++) begin
      int m;
      m = vecs[v].mode;
      pulse_clear(m);
      if (vecs[v].preload) push_tx(m, vecs[v].hold);
      ssel_assert(m);
      check("busy_active", 32'(busy[m]), 32'd1);
      check("tx_ready_at_entry", 32'(tx_ready[m]), 32'd1);
      check("underrun_at_entry", 32'(und[m]), 32'(vecs[v].exp_und));
      push_tx(m, 32'hFFFF_FFFF);
      xfer(m, vecs[v].mosi_w, 32, cap, 1'b0);
      sb.push_back(vecs[v].mosi_w);
      ssel_release(m);
      check("miso_word", cap, vecs[v].exp_miso);
      check("underrun_end", 32'(und[m]), 32'(vecs[v].exp_und));
      check("tx_ready_end", 32'(tx_ready[m]), 32'd1);
      check("idle_status", 32'(status(m)), {25'd0, 7'b0110000} | 32'(vecs[v].exp_und) << 1);
      pop_check(m, "rx_word");
      check("rx_empty", 32'(rx_valid[m]), 32'd0);
    end

    // Mode 3: eight back-to-back words, FIFO depth 4, no pops.
    pulse_clear(1);
    ssel_assert(1);
    for (int w = 1; w <= 8; w++) begin
      xfer(1, 32'(w), 32, cap, 1'b0);
      if (w <= 4) sb.push_back(32'(w));
    end
    ssel_release(1);
    check("overflow_set", 32'(ovf[1]), 32'd1);
    pulse_clear(1);
    check("overflow_cleared", 32'(ovf[1]), 32'd0);
    for (int k = 0; k < 4; k++) pop_check(1, "ovf_fifo_word");
    check("ovf_fifo_empty", 32'(rx_valid[1]), 32'd0);

    // Mode 0: SSEL released after 13 bits, then a clean frame.
    pulse_clear(0);
    ssel_assert(0);
    xfer(0, 32'hFFFF_FFFF, 13, cap, 1'b0);
    ssel_release(0);
    check("abort_set", 32'(abrt[0]), 32'd1);
    check("abort_no_push", 32'(rx_valid[0]), 32'd0);
    pulse_clear(0);
    check("abort_cleared", 32'(abrt[0]), 32'd0);
    ssel_assert(0);
    xfer(0, 32'h600D_F00D, 32, cap, 1'b0);
    sb.push_back(32'h600D_F00D);
    ssel_release(0);
    check("abort_not_reset", 32'(abrt[0]), 32'd0);
    pop_check(0, "after_abort_word");

    // Mode 0: fill the FIFO, then pop in the cycle the fifth word is pushed.
    pulse_clear(0);
    ssel_assert(0);
    for (int w = 1; w <= 4; w++) begin
      xfer(0, 32'h100 + 32'(w), 32, cap, 1'b0);
      sb.push_back(32'h100 + 32'(w));
    end
    xfer(0, 32'h105, 32, cap, 1'b1);
    sb.push_back(32'h105);
    ssel_release(0);
    check("simul_no_overflow", 32'(ovf[0]), 32'd0);
    for (int k = 0; k < 4; k++) pop_check(0, "simul_fifo_word");
    check("simul_fifo_empty", 32'(rx_valid[0]), 32'd0);

    // Mode 0: asynchronous reset in the middle of a frame.
    pulse_clear(0);
    ssel_assert(0);
    xfer(0, 32'h0BAD_CAFE, 32, cap, 1'b0);
    push_tx(0, 32'hC0DE_0001);
    xfer(0, 32'hFFFF_FFFF, 10, cap, 1'b0);
    check("pre_reset_rx_valid", 32'(rx_valid[0]), 32'd1);
    reset_n = 1'b0;
    #2;
    check("midframe_reset_status", 32'(status(0)), 32'b0100000);
    check("midframe_reset_rx_data", rx_data[0], 32'h0);
    ssel[0] = 1'b1;
    sck[0]  = 1'b0;
    mosi[0] = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    push_tx(0, 32'h5EED_1234);
    ssel_assert(0);
    check("post_reset_underrun", 32'(und[0]), 32'd0);
    push_tx(0, 32'hFFFF_FFFF);
    xfer(0, 32'h8765_4321, 32, cap, 1'b0);
    sb.push_back(32'h8765_4321);
    ssel_release(0);
    check("post_reset_miso", cap, 32'h5EED_1234);
    pop_check(0, "post_reset_word");

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d words left", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave) that sits on the far end of the team's AXI-SPI master link. It is used for loopback verification and as a peripheral-side front end.
- SCK, SSEL and MOSI are oversampled in the system clock domain.
- Received words are shifted into a small RX FIFO with a valid/ready drain.
- Transmit words come from a one-entry valid/ready holding register and are shifted out on MISO, MSB first.

Parameters:
- DATA_W, 32: frame length in bits (legal 4..32).
- CPOL, 0: idle level of SCK.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- RX_DEPTH, 4: RX FIFO entries (power of two, minimum 2).

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- spi_ssel_i  in  1  slave select, active low, asynchronous to clk_i.
- spi_sck_i  in  1  SPI clock, asynchronous to clk_i.
- spi_mosi_i  in  1  master-out data.
- spi_miso_o  out  1  slave-out data.
- tx_data_i  in  DATA_W  next word to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  holding register empty.
- rx_data_o  out  DATA_W  head of RX FIFO.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  pop RX FIFO.
- busy_o  out  1  SSEL active (synchronised).
- rx_overflow_o  out  1  sticky: word dropped because RX FIFO full.
- tx_underrun_o  out  1  sticky: frame started with empty holding register.
- frame_abort_o  out  1  sticky: SSEL released mid-frame.
- clear_i  in  1  one-cycle pulse that clears all sticky flags.

Behaviour:
- Reset values: spi_miso_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0, all sticky flags 0. Internally: FIFO empty, bit_cnt=0, shift registers 0.
- Synchronisation: SCK, SSEL and MOSI each pass through 2 flops. Edges are detected on the synced SCK (one extra flop).
- Timing requirements on the master:
  - SCK high and low times >= 4 clk_i periods.
  - SSEL assert to first SCK edge >= 4 clk_i periods.
- Edge definitions: leading edge is rising if CPOL=0, falling if CPOL=1. The sample edge is the leading edge if CPHA=0, else the trailing edge. The shift edge is the other one.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on synced SSEL falling. On entry: bit_cnt=0 and tx_shift loads the holding register.
  - If the holding register is empty at load, tx_shift loads 0 and tx_underrun_o is set.
- spi_miso_o = tx_shift[DATA_W-1] while ACTIVE, and 0 in IDLE.
- Sample edge: rx_shift = {rx_shift[DATA_W-2:0], mosi_sync}, then bit_cnt++.
  - When bit_cnt reaches DATA_W, the frame completes: the word is pushed to the RX FIFO and bit_cnt returns to 0.
  - tx_shift reloads from the holding register in the same cycle (underrun rule applies) to support back-to-back frames with SSEL held low.
- Shift edge: tx_shift shifts left by one only when bit_cnt != 0. This keeps the MSB valid for both CPHA settings at frame start.
- Holding register:
  - Accepts on tx_valid_i && tx_ready_o; tx_ready_o falls the next cycle.
  - It empties (tx_ready_o=1 the next cycle) when its content is loaded into tx_shift.
  - If a load and an accept happen in the same cycle, the load takes the old content and the new word is stored.
- RX FIFO:
  - Pop on rx_valid_i && rx_ready_i; rx_data_o is the head, first-word fall-through.
  - Push when full: the word is dropped, rx_overflow_o is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop happens first, so the push succeeds.
  - Pointers wrap modulo RX_DEPTH, with a count of RX_DEPTH+1 states.
- SSEL release (synced rising):
  - Go to IDLE.
  - If bit_cnt != 0: discard the partial word (no push) and set frame_abort_o.
  - The holding register keeps its content if it has not been loaded.
- SCK edges while IDLE are ignored.
- Sticky flags: set has priority over clear_i in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous).

Test Plan:
- Mode 0, DATA_W=32, holding=32'hA5A5_0001, master sends 32'h0000_0002 -> rx_data_o=32'h0000_0002 with rx_valid_o=1; master samples 32'hA5A5_0001 on MISO; tx_ready_o=1 afterwards.
- Mode 3 (CPOL=1, CPHA=1): 8 words 1..8 back-to-back under one SSEL, RX_DEPTH=4, no pops -> words 1..4 in FIFO, rx_overflow_o=1; after clear_i, flag=0 and a pop sequence yields 1,2,3,4.
- Empty holding register at SSEL assert -> MISO=0 for the whole frame, tx_underrun_o=1, RX word still captured.
- SSEL released after 13 of 32 bits -> no RX push, frame_abort_o=1, bit_cnt=0; next full frame received correctly.
- Simultaneous pop and push while full -> count stays RX_DEPTH, order preserved, no overflow.
- reset_n_i asserted mid-frame -> all outputs at reset values within the same cycle; after release, the next frame works.
